// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: latches one write request in IDLE,
// commits it for exactly one cycle in WRITE, round-robin on simultaneous requests.
module rf_write_arbiter #(
    parameter int DW   = 5,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_a,
    input  logic [AW-1:0]   addr_a,
    input  logic [DW-1:0]   data_a,
    input  logic            req_b,
    input  logic [AW-1:0]   addr_b,
    input  logic [DW-1:0]   data_b,
    output logic            gnt_a,
    output logic            gnt_b,
    output logic [NREG-1:0] rf_sel,
    output logic [DW-1:0]   rf_din,
    output logic            busy,
    output logic [NREG-1:0] rf_valid
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            take_s;
    logic            win_a_s;
    logic            win_a_r;
    logic            last_b_r;
    logic [AW-1:0]   addr_r;
    logic [DW-1:0]   data_r;
    logic [NREG-1:0] rf_valid_r;

    // Winner selection: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        take_s  = 1'b0;
        win_a_s = 1'b0;
        if (state_r == IDLE) begin
            take_s  = req_a | req_b;
            win_a_s = req_a & (~req_b | last_b_r);
        end else begin
            take_s  = 1'b0;
            win_a_s = 1'b0;
        end
    end

    // State register plus latched winner/address/data, last-grant pointer and valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            win_a_r    <= 1'b0;
            last_b_r   <= 1'b1;
            addr_r     <= {AW{1'b0}};
            data_r     <= {DW{1'b0}};
            rf_valid_r <= {NREG{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (take_s) begin
                win_a_r  <= win_a_s;
                last_b_r <= ~win_a_s;
                addr_r   <= win_a_s ? addr_a : addr_b;
                data_r   <= win_a_s ? data_a : data_b;
            end
            // The register loads at the edge closing WRITE, so validity follows it.
            if (state_r == WRITE) begin
                rf_valid_r <= rf_valid_r | rf_sel;
            end
        end
    end

    // Next-state logic: WRITE always lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = take_s ? WRITE : IDLE;
            WRITE:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: everything is driven from registers, zero outside WRITE.
    always_comb begin
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        rf_sel   = {NREG{1'b0}};
        rf_din   = {DW{1'b0}};
        busy     = 1'b0;
        rf_valid = rf_valid_r;
        case (state_r)
            WRITE: begin
                gnt_a  = win_a_r;
                gnt_b  = ~win_a_r;
                rf_sel = {{(NREG-1){1'b0}}, 1'b1} << addr_r;
                rf_din = data_r;
                busy   = 1'b1;
            end
            IDLE: begin
                busy = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DW, default 5, data width of each register-file entry.
REQ-002 Parameter NREG, default 4, number of register-file entries driven by the arbiter.
REQ-003 Parameter AW, default 2, register address width; NREG SHALL equal 2**AW.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_a  input  1  write request from requester A (load unit).
REQ-007 addr_a  input  AW  destination register index for A.
REQ-008 data_a  input  DW  write data for A.
REQ-009 req_b  input  1  write request from requester B (ALU writeback).
REQ-010 addr_b  input  AW  destination register index for B.
REQ-011 data_b  input  DW  write data for B.
REQ-012 gnt_a  output  1  one-cycle pulse; A's write is being committed this cycle.
REQ-013 gnt_b  output  1  one-cycle pulse; B's write is being committed this cycle.
REQ-014 rf_sel  output  NREG  one-hot load-enable, one bit per register's Sel input.
REQ-015 rf_din  output  DW  shared data bus to every register's Din.
REQ-016 busy  output  1  high while in WRITE state.
REQ-017 rf_valid  output  NREG  bit i set once register i has been written since reset.

Function
REQ-018 FSM states: IDLE, WRITE; two states only.
REQ-019 IDLE: if req_a or req_b high at a rising edge, the arbiter SHALL latch winner, address, data and enter WRITE; otherwise stay IDLE.
REQ-020 Only one requester high in IDLE -> that requester wins.
REQ-021 Both high in IDLE -> winner is the requester NOT granted most recently (round-robin); last-grant pointer updates on each entry to WRITE.
REQ-022 WRITE (exactly one cycle): rf_sel = one-hot of latched address, rf_din = latched data, winner's gnt pulsed, busy = 1; next state IDLE unconditionally.
REQ-023 Latency: request sampled at edge N -> rf_sel/gnt high in cycle N+1 -> target register loads at edge N+1.
REQ-024 Throughput: at most one write per two cycles; requests are never sampled in WRITE.
REQ-025 Outside WRITE: rf_sel = 0, rf_din = 0, gnt_a = gnt_b = 0, busy = 0.
REQ-026 gnt_a and gnt_b SHALL never be high in the same cycle; rf_sel SHALL never have more than one bit set.
REQ-027 Requesters hold req/addr/data stable until their gnt; req dropped at the gnt edge. Data changes after the sampling edge SHALL NOT affect rf_din.
REQ-028 Request held high after gnt is treated as a new request at the next IDLE edge.
REQ-029 Both requesters targeting the same address: serialized per REQ-021; the second write overwrites the first.
REQ-030 rf_valid[i] sets at the edge ending a WRITE to address i; sticky until reset.

Reset
REQ-031 reset high at a rising edge: state = IDLE, all outputs 0, rf_valid = 0, last-grant pointer = B (A wins the first tie).
REQ-032 Reset during WRITE aborts the cycle: rf_sel is 0 from the reset edge onward, no gnt issued afterwards, latched request discarded; rf_valid cleared.
REQ-033 reset overrides all requests in the same cycle.

Verification
REQ-034 After reset, req_a=1, addr_a=2, data_a=5'h13 for one edge -> next cycle rf_sel=4'b0100, rf_din=5'h13, gnt_a=1, busy=1; following cycle all zero, rf_valid=4'b0100.
REQ-035 After reset, req_a and req_b held high continuously (addr 0 and 1) -> gnt sequence A,B,A,B on alternate cycles; rf_sel alternates 0001/0010.
REQ-036 Both request addr 3, data_a=5'h01, data_b=5'h1F, simultaneous -> A granted first, then B; last rf_din at addr 3 is 5'h1F.
REQ-037 req_b sampled, data_b changed from 5'h0A to 5'h15 during WRITE -> rf_din = 5'h0A.
REQ-038 reset asserted in the WRITE cycle -> from the next cycle rf_sel=0, gnt=0, rf_valid=0, state IDLE; first tie afterwards goes to A.
REQ-039 Bench assertions throughout all runs: rf_sel one-hot or zero, gnt_a & gnt_b never both high, rf_din=0 when busy=0.
